// File: rtl/fetch_decode_buffer.sv
// fetch_decode_buffer: elastic IF/ID FIFO carrying {PC, PC+4, instr} from fetch to decode.
// Optional feature macro: FETCH_BUFFER_ILLEGAL_CHECK_EN adds out_illegal and one
// extra storage bit per entry. That bit flags a non-32-bit encoding or a misaligned PC.
// The reset port keeps the name "reset" but is asynchronous and active-low.
module fetch_decode_buffer #(
    parameter int DEPTH       = 2,
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PC_WIDTH-1:0]          in_pc,
    input  logic [PC_WIDTH-1:0]          in_pc4,
    input  logic [INSTR_WIDTH-1:0]       in_instr,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PC_WIDTH-1:0]          out_pc,
    output logic [PC_WIDTH-1:0]          out_pc4,
    output logic [INSTR_WIDTH-1:0]       out_instr,
`ifdef FETCH_BUFFER_ILLEGAL_CHECK_EN
    output logic                         out_illegal,
`endif
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
`ifdef FETCH_BUFFER_ILLEGAL_CHECK_EN
    localparam int ILL_W = 1;
`else
    localparam int ILL_W = 0;
`endif
    localparam int ENTRY_W = 2*PC_WIDTH + INSTR_WIDTH + ILL_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] entry_in;
    logic [ENTRY_W-1:0] head;
    logic               push;
    logic               pop;

    // Handshake flags come only from registered occupancy, so there is no ready path through decode.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        push      = in_valid & in_ready & ~flush;
        pop       = out_valid & out_ready & ~flush;
    end

    // Pack the incoming fetch bundle; the flag bit marks a compressed/odd encoding or a misaligned PC.
    always_comb begin
`ifdef FETCH_BUFFER_ILLEGAL_CHECK_EN
        entry_in = {((in_instr[1:0] != 2'b11) | (in_pc[1:0] != 2'b00)), in_pc, in_pc4, in_instr};
`else
        entry_in = {in_pc, in_pc4, in_instr};
`endif
    end

    // Next-state: flush wins over push/pop; otherwise write at wr_ptr, advance pointers, and track occupancy.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = entry_in;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State registers; reset clears storage too, so the outputs read zero while reset is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Head entry is read straight from registered storage; there is no bypass of a same-cycle push.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        out_pc    = head[2*PC_WIDTH+INSTR_WIDTH-1 -: PC_WIDTH];
        out_pc4   = head[PC_WIDTH+INSTR_WIDTH-1 -: PC_WIDTH];
        out_instr = head[INSTR_WIDTH-1:0];
        count     = count_q;
`ifdef FETCH_BUFFER_ILLEGAL_CHECK_EN
        out_illegal = out_valid & head[ENTRY_W-1];
`endif
    end

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// tb_fetch_decode_buffer: directed test of fetch_decode_buffer with DEPTH=2.
// Optional feature macro: FETCH_BUFFER_ILLEGAL_CHECK_EN enables the out_illegal steps.
module tb_fetch_decode_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_pc4;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;
    logic [31:0] out_instr;
    logic [1:0]  count;
`ifdef FETCH_BUFFER_ILLEGAL_CHECK_EN
    logic        out_illegal;
`endif

    int compared   = 0;
    int mismatched = 0;

    fetch_decode_buffer #(.DEPTH(2), .PC_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_pc4    (in_pc4),
        .in_instr  (in_instr),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_pc4   (out_pc4),
        .out_instr (out_instr),
`ifdef FETCH_BUFFER_ILLEGAL_CHECK_EN
        .out_illegal (out_illegal),
`endif
        .count     (count)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle's worth of inputs; pc4 is always derived as pc+4.
    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                                 input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_pc4    = pc + 32'd4;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
    endtask

    // Compare one observed value with its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Directed sequence covering reset, handshake, full/empty, streaming, flush and async reset.
    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #3;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_in_ready",  32'(in_ready),  32'd1);
        checkOutput("rst_count",     32'(count),     32'd0);
        checkOutput("rst_out_pc",    out_pc,         32'h0);
        tick();
        tick();
        reset = 1'b1;

        // Single push then pop.
        applyStimulus(1'b1, 32'h0, 32'h00500093, 1'b0, 1'b0);
        tick();
        checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
        checkOutput("t1_out_pc",    out_pc,         32'h0);
        checkOutput("t1_out_pc4",   out_pc4,        32'h4);
        checkOutput("t1_out_instr", out_instr,      32'h00500093);
        checkOutput("t1_count",     32'(count),     32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("t1_pop_count", 32'(count),     32'd0);
        checkOutput("t1_pop_valid", 32'(out_valid), 32'd0);

        // Fill while stalled, attempt a third push, then drain in order.
        applyStimulus(1'b1, 32'h0, 32'h00000013, 1'b0, 1'b0);
        tick();
        checkOutput("t2_count1",   32'(count),    32'd1);
        checkOutput("t2_in_ready1", 32'(in_ready), 32'd1);
        applyStimulus(1'b1, 32'h4, 32'h00000013, 1'b0, 1'b0);
        tick();
        checkOutput("t2_count2",    32'(count),    32'd2);
        checkOutput("t2_in_ready2", 32'(in_ready), 32'd0);
        applyStimulus(1'b1, 32'h8, 32'h00000013, 1'b0, 1'b0);
        tick();
        checkOutput("t2_full_count", 32'(count), 32'd2);
        checkOutput("t2_full_head",  out_pc,     32'h0);
        applyStimulus(1'b1, 32'h8, 32'h00000013, 1'b1, 1'b0);
        tick();
        checkOutput("t2_pop0_count", 32'(count), 32'd1);
        checkOutput("t2_pop0_head",  out_pc,     32'h4);
        tick();
        checkOutput("t2_retry_count", 32'(count), 32'd1);
        checkOutput("t2_retry_head",  out_pc,     32'h8);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("t2_drain_count", 32'(count), 32'd0);

        // Continuous streaming: one entry per cycle, occupancy pinned at one.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 32'(i * 4), 32'h00000013, 1'b1, 1'b0);
            tick();
            checkOutput("t3_stream_head",  out_pc,     32'(i * 4));
            checkOutput("t3_stream_count", 32'(count), 32'd1);
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("t3_drain_count", 32'(count), 32'd0);

        // Flush while full, with a same-cycle push and pop request.
        applyStimulus(1'b1, 32'h10, 32'h00000013, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h14, 32'h00000013, 1'b0, 1'b0);
        tick();
        checkOutput("t4_prefill_count", 32'(count), 32'd2);
        applyStimulus(1'b1, 32'h100, 32'h00000013, 1'b1, 1'b1);
        tick();
        checkOutput("t4_flush_count",    32'(count),     32'd0);
        checkOutput("t4_flush_valid",    32'(out_valid), 32'd0);
        checkOutput("t4_flush_in_ready", 32'(in_ready),  32'd1);
        applyStimulus(1'b1, 32'h200, 32'h00000013, 1'b0, 1'b0);
        tick();
        checkOutput("t4_after_head",  out_pc,     32'h200);
        checkOutput("t4_after_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("t4_drain_count", 32'(count), 32'd0);

        // Asynchronous reset mid-cycle with one entry held.
        applyStimulus(1'b1, 32'h30, 32'h00000093, 1'b0, 1'b0);
        tick();
        checkOutput("t5_pre_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("t5_rst_valid",    32'(out_valid), 32'd0);
        checkOutput("t5_rst_count",    32'(count),     32'd0);
        checkOutput("t5_rst_out_pc",   out_pc,         32'h0);
        checkOutput("t5_rst_out_inst", out_instr,      32'h0);
        checkOutput("t5_rst_in_ready", 32'(in_ready),  32'd1);
        tick();
        reset = 1'b1;
        applyStimulus(1'b1, 32'h40, 32'h00000013, 1'b0, 1'b0);
        tick();
        checkOutput("t5_after_head",  out_pc,     32'h40);
        checkOutput("t5_after_pc4",   out_pc4,    32'h44);
        checkOutput("t5_after_count", 32'(count), 32'd1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("t5_drain_count", 32'(count), 32'd0);

`ifdef FETCH_BUFFER_ILLEGAL_CHECK_EN
        // Illegal-flag tracking on the head entry.
        applyStimulus(1'b1, 32'h0, 32'h00000001, 1'b0, 1'b0);
        tick();
        checkOutput("t6_ill_encoding", 32'(out_illegal), 32'd1);
        applyStimulus(1'b1, 32'h2, 32'h00000013, 1'b1, 1'b0);
        tick();
        checkOutput("t6_ill_misalign", 32'(out_illegal), 32'd1);
        checkOutput("t6_misalign_pc",  out_pc,           32'h2);
        applyStimulus(1'b1, 32'h4, 32'h00000013, 1'b1, 1'b0);
        tick();
        checkOutput("t6_ill_clean",    32'(out_illegal), 32'd0);
        checkOutput("t6_clean_pc",     out_pc,           32'h4);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        tick();
        checkOutput("t6_drain_ill",    32'(out_illegal), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_decode_buffer.md
Name: fetch_decode_buffer

Overview:
- Elastic FIFO between the instruction-fetch stage and decode; acts as the IF/ID pipeline register.
- Captures {PC, PC+4, instr} from fetch with a valid/ready handshake and presents them to decode in order.
- Supports a decode-side stall (out_ready low) and a control-flow flush on taken jump/branch redirect.

Parameters:
DEPTH, 2, number of entries; power of two, >= 2
PC_WIDTH, 32, width of PC and PC+4 fields
INSTR_WIDTH, 32, instruction word width

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (buffer cleared while 0)
in_valid  input  1  fetch presents a valid entry
in_ready  output  1  buffer can accept an entry this cycle
in_pc  input  PC_WIDTH  Address of fetched instruction
in_pc4  input  PC_WIDTH  PC4 of fetched instruction
in_instr  input  INSTR_WIDTH  fetched instruction word
flush  input  1  discard all held entries and any same-cycle push
out_valid  output  1  head entry is valid
out_ready  input  1  decode consumes head this cycle
out_pc  output  PC_WIDTH  head PC
out_pc4  output  PC_WIDTH  head PC+4
out_instr  output  INSTR_WIDTH  head instruction
count  output  $clog2(DEPTH+1)  current occupancy

Behaviour:
- Storage: circular array, wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count tracks occupancy 0..DEPTH.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = (count != DEPTH); depends only on registered state, never on out_ready (no combinational ready path).
- out_valid = (count != 0); out_* = storage[rd_ptr], driven from registers.
- Latency: entry pushed at edge N appears on out_* after edge N (visible in cycle N+1); no same-cycle bypass.
- push & pop simultaneously: count unchanged, both pointers advance; legal at any occupancy 1..DEPTH-1. At count==DEPTH, in_ready=0, so only a pop occurs.
- Empty: out_valid=0, out_ready ignored, count stays 0.
- Full: in_valid ignored, no overwrite, count stays DEPTH.
- flush=1 at edge: count<=0, wr_ptr<=0, rd_ptr<=0; any in_valid and out_ready that cycle are ignored; out_valid=0 next cycle. Flush beats push and pop.
- Reset (reset=0, asynchronous): count, pointers, all storage entries <=0; out_valid=0, in_ready=1 while in reset, out_* = 0. Reset mid-stream drops all entries; first push after release lands in entry 0.
- Order strictly FIFO; no reordering or duplication.

Optional Feature:
FETCH_BUFFER_ILLEGAL_CHECK_EN
- Defined: adds output out_illegal (1 bit) and one extra storage bit per entry. At push, bit = (in_instr[1:0] != 2'b11) | (in_pc[1:0] != 2'b00), i.e. non-32-bit encoding or misaligned PC. out_illegal follows head entry; reset/flush to 0.
- Not defined: port and storage bit absent; behaviour otherwise identical.

Test Plan:
- Reset low, then release; push pc=0x0, pc4=0x4, instr=0x00500093 -> out_valid=1 next cycle with those values, count=1; pop with out_ready=1 -> count=0, out_valid=0.
- out_ready=0, push pc=0x0,0x4,0x8 on consecutive cycles (DEPTH=2) -> in_ready=0 after second push, third push not accepted, count=2; release out_ready -> outputs pc 0x0 then 0x4 in order, then in_valid retry of 0x8 accepted.
- Continuous in_valid/out_ready=1 with pc 0x0..0x3C -> one entry per cycle streamed, count stays 1, no loss, in-order.
- count=2, flush=1 with in_valid=1 (pc=0x100) and out_ready=1 -> next cycle count=0, out_valid=0; pc 0x100 never appears; next push pc=0x200 appears as head.
- count=1, drive reset=0 asynchronously mid-cycle -> out_valid drops immediately, count=0, out_* = 0; after release, push pc=0x40 appears as head.
- With FETCH_BUFFER_ILLEGAL_CHECK_EN: push instr=0x00000001 -> out_illegal=1; push pc=0x2, instr=0x00000013 -> out_illegal=1; push pc=0x4, instr=0x00000013 -> out_illegal=0.
